cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 23 ++
 rtl/cdb_arbiter.sv | 112 +++++++++++
 tb/tb_cdb_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU result inputs and common data bus outputs of the CDB arbiter
interface cdb_arbiter_if #(
  parameter int ROB   = 2,
  parameter int WIDTH = 31
);
  logic [2:0]             fuValid;
  logic [3*(ROB+1)-1:0]   fuRob;
  logic [3*(WIDTH+1)-1:0] fuResult;
  logic [2:0]             fuReady;
  logic                   validBroadcast;
  logic [ROB:0]           robEntry;
  logic [WIDTH:0]         result;

  modport master (
    output fuValid, fuRob, fuResult,
    input  fuReady, validBroadcast, robEntry, result
  );

  modport slave (
    input  fuValid, fuRob, fuResult,
    output fuReady, validBroadcast, robEntry, result
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - three 2-deep FU result queues feeding one CDB broadcast slot
// Round-robin pick among queues non-empty before the edge; broadcast is registered.
module cdb_arbiter #(
  parameter int ROB   = 2,
  parameter int WIDTH = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  localparam int RW = ROB + 1;
  localparam int DW = WIDTH + 1;

  logic [1:0]    r_count   [3];
  logic          r_head    [3];
  logic          r_tail    [3];
  logic [RW-1:0] r_rob_mem [3][2];
  logic [DW-1:0] r_res_mem [3][2];

  logic [1:0]    r_ptr;
  logic          r_valid;
  logic [RW-1:0] r_rob;
  logic [DW-1:0] r_result;

  logic [2:0]    w_ready;
  logic [2:0]    w_push;
  logic [2:0]    w_pop;
  logic          w_any;
  logic [1:0]    w_win;
  logic [1:0]    w_idx;

  // Ready looks only at pre-edge occupancy, so a full queue that pops stays not-ready.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_ready[i] = (r_count[i] < 2'd2) && !flush && !reset;
      w_push[i]  = bus.fuValid[i] && w_ready[i];
    end
  end

  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!w_any && (r_count[w_idx] != 2'd0)) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
      w_idx = (w_idx == 2'd2) ? 2'd0 : w_idx + 2'd1;
    end
    w_pop = 3'b000;
    if (w_any) begin
      w_pop[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (w_push[i]) begin
        r_rob_mem[i][r_tail[i]] <= bus.fuRob[i*RW +: RW];
        r_res_mem[i][r_tail[i]] <= bus.fuResult[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        r_count[i] <= 2'd0;
        r_head[i]  <= 1'b0;
        r_tail[i]  <= 1'b0;
      end
      r_ptr    <= 2'd0;
      r_valid  <= 1'b0;
      r_rob    <= '0;
      r_result <= '0;
    end else if (flush) begin
      for (int i = 0; i < 3; i++) begin
        r_count[i] <= 2'd0;
        r_head[i]  <= 1'b0;
        r_tail[i]  <= 1'b0;
      end
      r_valid <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_push[i]) begin
          r_tail[i] <= ~r_tail[i];
        end
        if (w_pop[i]) begin
          r_head[i] <= ~r_head[i];
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + 2'd1;
          2'b01:   r_count[i] <= r_count[i] - 2'd1;
          default: r_count[i] <= r_count[i];
        endcase
      end
      r_valid <= w_any;
      if (w_any) begin
        r_rob    <= r_rob_mem[w_win][r_head[w_win]];
        r_result <= r_res_mem[w_win][r_head[w_win]];
        r_ptr    <= (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
      end
    end
  end

  assign bus.fuReady        = w_ready;
  assign bus.validBroadcast = r_valid;
  assign bus.robEntry       = r_rob;
  assign bus.result         = r_result;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  logic clk;
  logic reset;
  logic flush;
  int   n_vec;
  int   n_err;

  cdb_arbiter_if #(.ROB(2), .WIDTH(31)) bus ();

  cdb_arbiter #(.ROB(2), .WIDTH(31)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v,
                       input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    bus.fuValid  = v;
    bus.fuRob    = {r2, r1, r0};
    bus.fuResult = {d2, d1, d0};
  endtask

  task automatic chk_bc(input string tag, input logic v, input logic [2:0] rob, input logic [31:0] res);
    n_vec++;
    assert (bus.validBroadcast === v) else begin
      n_err++;
      $error("FAIL %s validBroadcast got %0b want %0b", tag, bus.validBroadcast, v);
    end
    n_vec++;
    assert (bus.robEntry === rob) else begin
      n_err++;
      $error("FAIL %s robEntry got %0d want %0d", tag, bus.robEntry, rob);
    end
    n_vec++;
    assert (bus.result === res) else begin
      n_err++;
      $error("FAIL %s result got %h want %h", tag, bus.result, res);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic [2:0] exp);
    n_vec++;
    assert (bus.fuReady === exp) else begin
      n_err++;
      $error("FAIL %s fuReady got %b want %b", tag, bus.fuReady, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    reset = 1'b1;
    flush = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 0, 0);

    tick();
    tick();
    chk_rdy("rst_rdy", 3'b000);
    chk_bc("rst", 1'b0, 3'd0, 32'h0);
    reset = 1'b0;
    #1;
    chk_rdy("rdy_after_rst", 3'b111);

    // single push: two edges from acceptance to broadcast, one cycle long
    drive(3'b001, 3, 0, 0, 32'hAA, 0, 0);
    tick();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    chk_bc("sp_e0", 1'b0, 3'd0, 32'h0);
    tick();
    chk_bc("sp_e1", 1'b1, 3'd3, 32'hAA);
    tick();
    chk_bc("sp_hold", 1'b0, 3'd3, 32'hAA);

    // three-way contention from ptr = 0
    do_reset();
    drive(3'b111, 1, 2, 4, 32'h001, 32'h102, 32'h204);
    tick();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    chk_bc("c3_e0", 1'b0, 3'd0, 32'h0);
    tick();
    chk_bc("c3_fu0", 1'b1, 3'd1, 32'h001);
    tick();
    chk_bc("c3_fu1", 1'b1, 3'd2, 32'h102);
    tick();
    chk_bc("c3_fu2", 1'b1, 3'd4, 32'h204);
    tick();
    chk_bc("c3_idle", 1'b0, 3'd4, 32'h204);
    drive(3'b101, 6, 0, 7, 32'h006, 0, 32'h207);
    tick();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    chk_bc("c3_ptr0", 1'b1, 3'd6, 32'h006);
    tick();
    chk_bc("c3_then2", 1'b1, 3'd7, 32'h207);
    tick();
    chk_bc("c3_idle2", 1'b0, 3'd7, 32'h207);

    // round-robin wrap: FU1 win moves ptr to 2, then FIFO 2 beats FIFO 0
    do_reset();
    drive(3'b010, 0, 6, 0, 0, 32'h106, 0);
    tick();
    drive(3'b101, 1, 0, 2, 32'h001, 0, 32'h202);
    tick();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    chk_bc("rr_fu1", 1'b1, 3'd6, 32'h106);
    tick();
    chk_bc("rr_wrap2", 1'b1, 3'd2, 32'h202);
    tick();
    chk_bc("rr_wrap0", 1'b1, 3'd1, 32'h001);
    tick();
    chk_bc("rr_idle", 1'b0, 3'd1, 32'h001);

    // backpressure on FU 0 while FUs 1 and 2 win
    do_reset();
    drive(3'b001, 0, 0, 0, 32'h0EE, 0, 0);
    tick();
    drive(3'b111, 5, 1, 4, 32'h005, 32'h101, 32'h204);
    tick();
    chk_bc("bp_dummy", 1'b1, 3'd0, 32'h0EE);
    drive(3'b111, 6, 2, 3, 32'h006, 32'h102, 32'h203);
    chk_rdy("bp_rdy_e3", 3'b111);
    tick();
    chk_bc("bp_fu1a", 1'b1, 3'd1, 32'h101);
    drive(3'b011, 7, 3, 0, 32'h007, 32'h103, 0);
    chk_rdy("bp_rdy_full", 3'b010);
    tick();
    chk_bc("bp_fu2a", 1'b1, 3'd4, 32'h204);
    drive(3'b001, 7, 0, 0, 32'h007, 0, 0);
    chk_rdy("bp_rdy_pop", 3'b100);
    tick();
    chk_bc("bp_rob5", 1'b1, 3'd5, 32'h005);
    chk_rdy("bp_rdy_free", 3'b101);
    tick();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    chk_bc("bp_fu1b", 1'b1, 3'd2, 32'h102);
    tick();
    chk_bc("bp_fu2b", 1'b1, 3'd3, 32'h203);
    tick();
    chk_bc("bp_rob6", 1'b1, 3'd6, 32'h006);
    tick();
    chk_bc("bp_fu1c", 1'b1, 3'd3, 32'h103);
    tick();
    chk_bc("bp_rob7", 1'b1, 3'd7, 32'h007);
    tick();
    chk_bc("bp_idle", 1'b0, 3'd7, 32'h007);

    // flush with all queues occupied
    do_reset();
    drive(3'b111, 1, 2, 3, 32'h001, 32'h102, 32'h203);
    tick();
    drive(3'b111, 4, 5, 6, 32'h004, 32'h105, 32'h206);
    tick();
    chk_bc("fl_pre", 1'b1, 3'd1, 32'h001);
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    #1;
    chk_rdy("fl_rdy_low", 3'b000);
    tick();
    chk_bc("fl_valid0", 1'b0, 3'd1, 32'h001);
    flush = 1'b0;
    #1;
    chk_rdy("fl_rdy_after", 3'b111);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bc("fl_quiet", 1'b0, 3'd1, 32'h001);
    end
    drive(3'b010, 0, 7, 0, 0, 32'h107, 0);
    tick();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    chk_bc("fl_new", 1'b1, 3'd7, 32'h107);

    // reset mid-stream; ptr is 2 here so FU 2 wins first
    drive(3'b111, 1, 2, 3, 32'h001, 32'h102, 32'h203);
    tick();
    drive(3'b111, 4, 5, 6, 32'h004, 32'h105, 32'h206);
    tick();
    chk_bc("rm_pre", 1'b1, 3'd3, 32'h203);
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    chk_bc("rm_reset", 1'b0, 3'd0, 32'h0);
    reset = 1'b0;
    #1;
    chk_rdy("rm_rdy", 3'b111);
    tick();
    chk_bc("rm_empty", 1'b0, 3'd0, 32'h0);
    drive(3'b101, 1, 0, 2, 32'h001, 0, 32'h202);
    tick();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    chk_bc("rm_ptr0", 1'b1, 3'd1, 32'h001);
    tick();
    chk_bc("rm_then2", 1'b1, 3'd2, 32'h202);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
